// File: rtl/haraka_serializer_if.sv
// Handshake bundle between the Haraka sponge permutation, the serializer and the serial sink.
// The slave modport is the serializer's view; the master modport is the surrounding logic's view.
interface haraka_serializer_if #(
    parameter int unsigned INWIDTH  = 256,
    parameter int unsigned OUTWIDTH = 1
);
    logic                start;
    logic [15:0]         out_len;
    logic [INWIDTH-1:0]  block_in;
    logic                block_valid;
    logic                block_ready;
    logic                squeeze_req;
    logic [OUTWIDTH-1:0] serial_out;
    logic                serial_valid;
    logic                serial_ready;
    logic                busy;
    logic                done;

    modport slave (
        input  start, out_len, block_in, block_valid, serial_ready,
        output block_ready, squeeze_req, serial_out, serial_valid, busy, done
    );

    modport master (
        output start, out_len, block_in, block_valid, serial_ready,
        input  block_ready, squeeze_req, serial_out, serial_valid, busy, done
    );
endinterface

// File: rtl/haraka_serializer.sv
// Squeeze-side serializer: pulls INWIDTH-bit blocks from the permutation on demand and
// streams out_len words of OUTWIDTH bits each, LSB first, with a valid/ready sink handshake.
module haraka_serializer #(
    parameter int unsigned INWIDTH  = 256,
    parameter int unsigned OUTWIDTH = 1
) (
    input  logic                clk,
    input  logic                clear,
    haraka_serializer_if.slave  bus
);
    localparam int unsigned WORDS = INWIDTH / OUTWIDTH;
    localparam int unsigned CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLOCK,
        SHIFT,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [INWIDTH-1:0] sreg_q, sreg_d;
    logic [15:0]        remaining_q, remaining_d;
    logic [CW-1:0]      word_cnt_q, word_cnt_d;
    logic               squeeze_q, squeeze_d;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            remaining_q <= '0;
            word_cnt_q  <= '0;
            squeeze_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            remaining_q <= remaining_d;
            word_cnt_q  <= word_cnt_d;
            squeeze_q   <= squeeze_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        remaining_d = remaining_q;
        word_cnt_d  = word_cnt_q;
        squeeze_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.out_len != 16'd0) begin
                        state_d     = WAIT_BLOCK;
                        remaining_d = bus.out_len;
                        squeeze_d   = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT_BLOCK: begin
                if (bus.block_valid) begin
                    sreg_d     = bus.block_in;
                    word_cnt_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.serial_ready) begin
                    sreg_d      = sreg_q >> OUTWIDTH;
                    remaining_d = remaining_q - 16'd1;
                    word_cnt_d  = word_cnt_q + 1'b1;
                    // Session end wins over block exhaustion so no surplus block is requested.
                    if (remaining_q == 16'd1) begin
                        state_d = DONE;
                    end else if (word_cnt_q == LAST_WORD) begin
                        state_d   = WAIT_BLOCK;
                        squeeze_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.block_ready  = (state_q == WAIT_BLOCK);
    assign bus.serial_valid = (state_q == SHIFT);
    assign bus.serial_out   = sreg_q[OUTWIDTH-1:0];
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.squeeze_req  = squeeze_q;
endmodule

// File: tb/tb_haraka_serializer.sv
// Directed bench for haraka_serializer (INWIDTH=256, OUTWIDTH=1): a negedge monitor records
// transfers and pulses, and each scenario task checks them against hand-derived values.
module tb_haraka_serializer;
    logic clk;
    logic clear;

    haraka_serializer_if #(.INWIDTH(256), .OUTWIDTH(1)) u_if ();

    haraka_serializer #(.INWIDTH(256), .OUTWIDTH(1)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Block source: entry nacc is presented; nacc advances the cycle after an accept.
    logic [255:0] blk_tab [4];
    logic [1:0]   nacc;
    assign u_if.block_in = blk_tab[nacc];

    int   cyc = 0;
    int   epoch = 0;
    int   seen_epoch = 0;
    int   sq_cnt, done_cnt, sv_cnt, stab_err;
    int   sq_cyc, done_cyc, acc_cyc, st_cyc, first_cyc, last_cyc;
    logic bits [$];
    logic held;
    bit   hold_flag;
    bit   acc_pend;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                bits.delete();
                sq_cnt = 0; done_cnt = 0; sv_cnt = 0; stab_err = 0;
                sq_cyc = -1; done_cyc = -1; acc_cyc = -1; st_cyc = -1;
                first_cyc = -1; last_cyc = -1;
                nacc = 2'd0; acc_pend = 1'b0; hold_flag = 1'b0; held = 1'b0;
            end
            if (acc_pend) nacc = nacc + 2'd1;
            acc_pend = 1'b0;
            if (!clear) begin
                if (u_if.squeeze_req) begin
                    sq_cnt++;
                    if (sq_cyc < 0) sq_cyc = cyc;
                end
                if (u_if.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (u_if.serial_valid) sv_cnt++;
                if (u_if.block_ready && u_if.block_valid) begin
                    acc_pend = 1'b1;
                    if (acc_cyc < 0) acc_cyc = cyc;
                end
                if (u_if.start && !u_if.busy && st_cyc < 0) st_cyc = cyc;
                if (hold_flag && u_if.serial_valid && u_if.serial_out[0] !== held) stab_err++;
                hold_flag = u_if.serial_valid && !u_if.serial_ready;
                held = u_if.serial_out[0];
                if (u_if.serial_valid && u_if.serial_ready) begin
                    bits.push_back(u_if.serial_out[0]);
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [15:0] len);
        epoch++;
        tick();
        u_if.start   = 1'b1;
        u_if.out_len = len;
        tick();
        u_if.start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && done_cnt < n; i++) tick();
        ok = (done_cnt >= n);
    endtask

    task automatic test_reset();
        clear = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++; if (u_if.block_ready !== 1'b0) begin bad++; $display("FAIL reset_block_ready: got %b want 0", u_if.block_ready); end
        total++; if (u_if.squeeze_req !== 1'b0) begin bad++; $display("FAIL reset_squeeze_req: got %b want 0", u_if.squeeze_req); end
        total++; if (u_if.serial_valid !== 1'b0) begin bad++; $display("FAIL reset_serial_valid: got %b want 0", u_if.serial_valid); end
        total++; if (u_if.serial_out !== 1'b0) begin bad++; $display("FAIL reset_serial_out: got %b want 0", u_if.serial_out); end
        total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", u_if.busy); end
        total++; if (u_if.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", u_if.done); end
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic test_single_block();
        logic [255:0] a;
        bit ok;
        int nerr;
        int first_bad;
        a = 256'h1;
        blk_tab[0] = a;
        u_if.serial_ready = 1'b1;
        start_session(16'd256);
        wait_done(1, 600, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout: done_cnt %0d want 1", done_cnt); end
        tick();
        nerr = 0; first_bad = -1;
        for (int i = 0; i < bits.size(); i++) begin
            if (bits[i] !== a[i]) begin nerr++; if (first_bad < 0) first_bad = i; end
        end
        total++; if (sq_cnt !== 1) begin bad++; $display("FAIL single_squeeze_cnt: got %0d want 1", sq_cnt); end
        total++; if (bits.size() !== 256) begin bad++; $display("FAIL single_bit_cnt: got %0d want 256", bits.size()); end
        total++; if (nerr !== 0) begin bad++; $display("FAIL single_bits: %0d wrong, first at %0d, want 1 then zeros", nerr, first_bad); end
        total++; if (sq_cyc - st_cyc !== 1) begin bad++; $display("FAIL single_squeeze_lat: got %0d want 1", sq_cyc - st_cyc); end
        total++; if (first_cyc - acc_cyc !== 1) begin bad++; $display("FAIL single_first_word_lat: got %0d want 1", first_cyc - acc_cyc); end
        total++; if (done_cyc - last_cyc !== 1) begin bad++; $display("FAIL single_done_lat: got %0d want 1", done_cyc - last_cyc); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_two_blocks();
        logic [255:0] a;
        logic [255:0] b;
        logic expb;
        bit ok;
        int nerr;
        int first_bad;
        a = {8{32'hDEADBEEF}};
        b = {4{64'h0123456789ABCDEF}};
        blk_tab[0] = a;
        blk_tab[1] = b;
        u_if.serial_ready = 1'b1;
        start_session(16'd300);
        u_if.out_len = 16'd3;
        wait_done(1, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL two_timeout: done_cnt %0d want 1", done_cnt); end
        tick();
        nerr = 0; first_bad = -1;
        for (int i = 0; i < bits.size(); i++) begin
            expb = (i < 256) ? a[i] : b[i - 256];
            if (bits[i] !== expb) begin nerr++; if (first_bad < 0) first_bad = i; end
        end
        total++; if (sq_cnt !== 2) begin bad++; $display("FAIL two_squeeze_cnt: got %0d want 2", sq_cnt); end
        total++; if (bits.size() !== 300) begin bad++; $display("FAIL two_bit_cnt: got %0d want 300", bits.size()); end
        total++; if (nerr !== 0) begin bad++; $display("FAIL two_bits: %0d wrong, first at %0d", nerr, first_bad); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL two_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall();
        logic [255:0] a;
        int nerr;
        int first_bad;
        a = {8{32'hDEADBEEF}};
        blk_tab[0] = a;
        u_if.serial_ready = 1'b0;
        start_session(16'd40);
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            u_if.serial_ready = ~u_if.serial_ready;
            u_if.start   = (i == 5);
            u_if.out_len = 16'd7;
            tick();
        end
        u_if.start = 1'b0;
        u_if.serial_ready = 1'b1;
        total++; if (done_cnt == 0) begin bad++; $display("FAIL stall_timeout: done_cnt %0d want 1", done_cnt); end
        tick();
        tick();
        nerr = 0; first_bad = -1;
        for (int i = 0; i < bits.size(); i++) begin
            if (bits[i] !== a[i]) begin nerr++; if (first_bad < 0) first_bad = i; end
        end
        total++; if (bits.size() !== 40) begin bad++; $display("FAIL stall_bit_cnt: got %0d want 40", bits.size()); end
        total++; if (nerr !== 0) begin bad++; $display("FAIL stall_bits: %0d wrong, first at %0d", nerr, first_bad); end
        total++; if (stab_err !== 0) begin bad++; $display("FAIL stall_hold: %0d changes while stalled, want 0", stab_err); end
        total++; if (sq_cnt !== 1) begin bad++; $display("FAIL stall_squeeze_cnt: got %0d want 1", sq_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_len();
        u_if.serial_ready = 1'b1;
        start_session(16'd0);
        tick();
        tick();
        tick();
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
        total++; if (done_cyc - st_cyc !== 1) begin bad++; $display("FAIL zero_done_lat: got %0d want 1", done_cyc - st_cyc); end
        total++; if (sq_cnt !== 0) begin bad++; $display("FAIL zero_squeeze_cnt: got %0d want 0", sq_cnt); end
        total++; if (sv_cnt !== 0) begin bad++; $display("FAIL zero_serial_valid: got %0d cycles want 0", sv_cnt); end
    endtask

    task automatic test_abort();
        logic [255:0] a;
        int nerr;
        int k;
        a = {8{32'hDEADBEEF}};
        blk_tab[0] = a;
        u_if.serial_ready = 1'b1;
        start_session(16'd256);
        k = 0;
        while (bits.size() < 100 && k < 300) begin tick(); k++; end
        total++; if (bits.size() < 100) begin bad++; $display("FAIL abort_timeout: got %0d bits want 100", bits.size()); end
        clear = 1'b1;
        tick();
        @(negedge clk);
        total++; if (u_if.block_ready !== 1'b0) begin bad++; $display("FAIL abort_block_ready: got %b want 0", u_if.block_ready); end
        total++; if (u_if.squeeze_req !== 1'b0) begin bad++; $display("FAIL abort_squeeze_req: got %b want 0", u_if.squeeze_req); end
        total++; if (u_if.serial_valid !== 1'b0) begin bad++; $display("FAIL abort_serial_valid: got %b want 0", u_if.serial_valid); end
        total++; if (u_if.serial_out !== 1'b0) begin bad++; $display("FAIL abort_serial_out: got %b want 0", u_if.serial_out); end
        total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", u_if.busy); end
        total++; if (u_if.done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", u_if.done); end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_done_pulse: got %0d want 0", done_cnt); end
        tick();
        clear = 1'b0;
        start_session(16'd8);
        k = 0;
        while (done_cnt == 0 && k < 50) begin tick(); k++; end
        tick();
        nerr = 0;
        for (int i = 0; i < bits.size(); i++) if (bits[i] !== a[i]) nerr++;
        total++; if (bits.size() !== 8) begin bad++; $display("FAIL abort_restart_bit_cnt: got %0d want 8", bits.size()); end
        total++; if (nerr !== 0) begin bad++; $display("FAIL abort_restart_bits: %0d wrong want 0", nerr); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL abort_restart_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_held();
        logic [255:0] c;
        bit ok;
        int nerr;
        c = {4{64'hF0E1D2C3B4A59687}};
        blk_tab[0] = c;
        blk_tab[1] = c;
        u_if.serial_ready = 1'b1;
        epoch++;
        tick();
        u_if.out_len = 16'd16;
        u_if.start   = 1'b1;
        wait_done(2, 200, ok);
        u_if.start = 1'b0;
        tick();
        tick();
        tick();
        nerr = 0;
        for (int i = 0; i < bits.size(); i++) if (bits[i] !== c[i % 16]) nerr++;
        total++; if (done_cnt !== 2) begin bad++; $display("FAIL held_done_cnt: got %0d want 2", done_cnt); end
        total++; if (sq_cnt !== 2) begin bad++; $display("FAIL held_squeeze_cnt: got %0d want 2", sq_cnt); end
        total++; if (bits.size() !== 32) begin bad++; $display("FAIL held_bit_cnt: got %0d want 32", bits.size()); end
        total++; if (nerr !== 0) begin bad++; $display("FAIL held_loopback: %0d wrong bits want 0", nerr); end
    endtask

    initial begin
        clear = 1'b1;
        u_if.start = 1'b0;
        u_if.out_len = 16'd0;
        u_if.block_valid = 1'b1;
        u_if.serial_ready = 1'b1;
        for (int i = 0; i < 4; i++) blk_tab[i] = '0;
        test_reset();
        test_single_block();
        test_two_blocks();
        test_stall();
        test_zero_len();
        test_abort();
        test_start_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
